// File: rtl/pixel_sink_pkg.sv
// Shared types for pixel_stream_sink: FSM state encoding, signed coordinate type
// and a saturating counter helper.
package pixel_sink_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        LAUNCH,
        STREAM,
        DRAIN,
        DONE
    } state_t;

    typedef logic signed [31:0] coord_t;

    localparam logic [31:0] CNT_MAX = '1;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == CNT_MAX) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/fb_skid_fifo.sv
// Two-entry FIFO holding framebuffer write addresses between the stream side
// and the write port. Push while full is accepted only with a simultaneous pop.
module fb_skid_fifo #(
    parameter int W = 12
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         push_i,
    input  logic [W-1:0] din_i,
    input  logic         pop_i,
    output logic         full_o,
    output logic         empty_o,
    output logic [W-1:0] dout_o
);

    logic [W-1:0] mem_q [2];
    logic         rd_q;
    logic         wr_q;
    logic [1:0]   count_q;
    logic [1:0]   count_d;
    logic         do_push;
    logic         do_pop;

    assign full_o  = (count_q == 2'd2);
    assign empty_o = (count_q == 2'd0);
    assign dout_o  = mem_q[rd_q];

    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_comb begin
        count_d = count_q + {1'b0, do_push} - {1'b0, do_pop};
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            rd_q     <= 1'b0;
            wr_q     <= 1'b0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_q] <= din_i;
                wr_q        <= ~wr_q;
            end
            if (do_pop) begin
                rd_q <= ~rd_q;
            end
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/pixel_stream_sink.sv
// Generator-stream consumer: launches a generator, clips incoming (x,y) pairs to
// the frame and writes in-frame pixels to the framebuffer. CLEAR_ON_START_EN adds a clear sweep.
module pixel_stream_sink
    import pixel_sink_pkg::*;
#(
    parameter int               WIDTH    = 64,
    parameter int               HEIGHT   = 64,
    parameter int               COLOR_W  = 8,
    parameter logic [COLOR_W-1:0] FG_COLOR = 8'hFF,
    parameter logic [COLOR_W-1:0] BG_COLOR = 8'h00,
    localparam int              ADDR_W   = $clog2(WIDTH * HEIGHT)
) (
    input  logic               _clock,
    input  logic               _reset,
    input  logic               host_go,
    output logic               host_busy,
    output logic               host_done,
    output logic [31:0]        pix_count,
    output logic [31:0]        clip_count,
    output logic               _start,
    output logic               _ready,
    input  logic               _valid,
    input  logic               _done,
    input  coord_t             _out0,
    input  coord_t             _out1,
    output logic               fb_we,
    output logic [ADDR_W-1:0]  fb_addr,
    output logic [COLOR_W-1:0] fb_wdata,
    input  logic               fb_ack
);

    state_t            state_q;
    logic [31:0]       pix_q;
    logic [31:0]       clip_q;
    logic              in_frame;
    logic              take;
    logic [ADDR_W-1:0] push_addr;
    logic              fifo_push;
    logic              fifo_pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [ADDR_W-1:0] fifo_head;

`ifdef CLEAR_ON_START_EN
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(WIDTH * HEIGHT - 1);
    logic [ADDR_W-1:0] clr_q;
`endif

    // Range check uses the full signed coordinates; the address is only formed
    // modulo 2^ADDR_W, which is exact for in-frame pairs.
    assign in_frame  = (_out0 >= 0) && (_out0 < WIDTH) && (_out1 >= 0) && (_out1 < HEIGHT);
    assign push_addr = ADDR_W'(_out1) * ADDR_W'(WIDTH) + ADDR_W'(_out0);
    assign take      = (state_q == STREAM) && _valid && _ready;
    assign fifo_push = take && in_frame;
    assign fifo_pop  = !fifo_empty && fb_ack;

    fb_skid_fifo #(
        .W(ADDR_W)
    ) u_fifo (
        .clk_i  (_clock),
        .rst_i  (_reset),
        .push_i (fifo_push),
        .din_i  (push_addr),
        .pop_i  (fifo_pop),
        .full_o (fifo_full),
        .empty_o(fifo_empty),
        .dout_o (fifo_head)
    );

    assign host_busy  = (state_q != IDLE);
    assign host_done  = (state_q == DONE);
    assign _start     = (state_q == LAUNCH);
    assign pix_count  = pix_q;
    assign clip_count = clip_q;

    always_comb begin
        _ready   = (state_q == STREAM) && !fifo_full;
        fb_we    = !fifo_empty;
        fb_addr  = fifo_empty ? '0 : fifo_head;
        fb_wdata = !fifo_empty ? FG_COLOR : ((state_q == IDLE) ? '0 : BG_COLOR);
`ifdef CLEAR_ON_START_EN
        if (state_q == CLEAR) begin
            fb_we    = 1'b1;
            fb_addr  = clr_q;
            fb_wdata = BG_COLOR;
        end
`endif
    end

    always_ff @(posedge _clock or posedge _reset) begin
        if (_reset) begin
            state_q <= IDLE;
            pix_q   <= '0;
            clip_q  <= '0;
`ifdef CLEAR_ON_START_EN
            clr_q   <= '0;
`endif
        end else begin
            if (fifo_pop) begin
                pix_q <= sat_inc(pix_q);
            end
            case (state_q)
                IDLE: begin
                    if (host_go) begin
                        pix_q  <= '0;
                        clip_q <= '0;
`ifdef CLEAR_ON_START_EN
                        clr_q   <= '0;
                        state_q <= CLEAR;
`else
                        state_q <= LAUNCH;
`endif
                    end
                end
`ifdef CLEAR_ON_START_EN
                CLEAR: begin
                    if (fb_ack) begin
                        if (clr_q == LAST_ADDR) begin
                            state_q <= LAUNCH;
                        end else begin
                            clr_q <= clr_q + ADDR_W'(1);
                        end
                    end
                end
`endif
                LAUNCH: state_q <= STREAM;
                STREAM: begin
                    if (take && !in_frame) begin
                        clip_q <= sat_inc(clip_q);
                    end
                    if (_done && _ready) begin
                        state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (fifo_empty) begin
                        state_q <= DONE;
                    end
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pixel_stream_sink.sv
// Directed bench for pixel_stream_sink (64x64 frame); honours CLEAR_ON_START_EN.
module tb_pixel_stream_sink;

    logic               clk = 1'b0;
    logic               rst;
    logic               host_go;
    logic               host_busy;
    logic               host_done;
    logic [31:0]        pix_count;
    logic [31:0]        clip_count;
    logic               gen_start;
    logic               gen_ready;
    logic               gen_valid;
    logic               gen_done;
    logic signed [31:0] gen_out0;
    logic signed [31:0] gen_out1;
    logic               fb_we;
    logic [11:0]        fb_addr;
    logic [7:0]         fb_wdata;
    logic               fb_ack;

    int checks   = 0;
    int failures = 0;
    int starts   = 0;
    int dones    = 0;
    logic [11:0] wa_q [$];
    logic [7:0]  wd_q [$];

    pixel_stream_sink #(
        .WIDTH   (64),
        .HEIGHT  (64),
        .COLOR_W (8),
        .FG_COLOR(8'hFF),
        .BG_COLOR(8'h00)
    ) dut (
        ._clock    (clk),
        ._reset    (rst),
        .host_go   (host_go),
        .host_busy (host_busy),
        .host_done (host_done),
        .pix_count (pix_count),
        .clip_count(clip_count),
        ._start    (gen_start),
        ._ready    (gen_ready),
        ._valid    (gen_valid),
        ._done     (gen_done),
        ._out0     (gen_out0),
        ._out1     (gen_out1),
        .fb_we     (fb_we),
        .fb_addr   (fb_addr),
        .fb_wdata  (fb_wdata),
        .fb_ack    (fb_ack)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (fb_we && fb_ack) begin
            wa_q.push_back(fb_addr);
            wd_q.push_back(fb_wdata);
        end
        if (gen_start) starts++;
        if (host_done) dones++;
    end

    task automatic tick;
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic start_run;
        int cb;
        cb = wa_q.size();
        host_go = 1'b1;
        tick;
        host_go = 1'b0;
        chk("go_clears_pix", pix_count, 0);
        chk("go_clears_clip", clip_count, 0);
`ifdef CLEAR_ON_START_EN
        begin
            int n;
            int bad;
            n = 0;
            while (!gen_start && n < 6000) begin
                tick;
                n++;
            end
            chk("start_after_clear", {31'd0, gen_start}, 1);
            chk("clear_write_count", wa_q.size() - cb, 4096);
            bad = 0;
            for (int i = 0; i < wa_q.size() - cb; i++) begin
                if (wa_q[cb + i] != 12'(i) || wd_q[cb + i] != 8'h00) bad++;
            end
            chk("clear_content", bad, 0);
        end
`else
        chk("start_one_cycle_after_go", {31'd0, gen_start}, 1);
        chk("no_write_before_start", wa_q.size() - cb, 0);
`endif
    endtask

    task automatic send(input logic signed [31:0] px, input logic signed [31:0] py,
                        input logic vld, input logic dn);
        int n;
        n = 0;
        gen_valid = vld;
        gen_out0  = px;
        gen_out1  = py;
        gen_done  = dn;
        while (!gen_ready && n < 200) begin
            tick;
            n++;
        end
        chk("ready_wait", {31'd0, gen_ready}, 1);
        tick;
        gen_valid = 1'b0;
        gen_done  = 1'b0;
    endtask

    task automatic wait_done;
        int n;
        n = 0;
        while (!host_done && n < 100) begin
            tick;
            n++;
        end
        chk("host_done_seen", {31'd0, host_done}, 1);
        tick;
        chk("host_done_one_cycle", {31'd0, host_done}, 0);
        chk("idle_after_done", {31'd0, host_busy}, 0);
    endtask

    initial begin
        int wb;
        int s0;
        int d0;
        rst       = 1'b1;
        host_go   = 1'b0;
        gen_valid = 1'b0;
        gen_done  = 1'b0;
        gen_out0  = '0;
        gen_out1  = '0;
        fb_ack    = 1'b0;
        tick;
        tick;
        chk("rst_busy", {31'd0, host_busy}, 0);
        chk("rst_done", {31'd0, host_done}, 0);
        chk("rst_pix", pix_count, 0);
        chk("rst_clip", clip_count, 0);
        chk("rst_start", {31'd0, gen_start}, 0);
        chk("rst_ready", {31'd0, gen_ready}, 0);
        chk("rst_we", {31'd0, fb_we}, 0);
        chk("rst_addr", {20'd0, fb_addr}, 0);
        chk("rst_wdata", {24'd0, fb_wdata}, 0);
        rst = 1'b0;
        tick;

        // 1: basic clip and write
        fb_ack = 1'b1;
        s0 = starts;
        d0 = dones;
        start_run;
        wb = wa_q.size();
        tick;
        chk("t1_start_dropped", {31'd0, gen_start}, 0);
        send(54, 52, 1'b1, 1'b0);
        send(46, 52, 1'b1, 1'b0);
        send(-1, 5, 1'b1, 1'b0);
        send(64, 0, 1'b1, 1'b0);
        send(0, 0, 1'b0, 1'b1);
        wait_done;
        chk("t1_writes", wa_q.size() - wb, 2);
        chk("t1_addr0", {20'd0, wa_q[wb]}, 3382);
        chk("t1_addr1", {20'd0, wa_q[wb + 1]}, 3374);
        chk("t1_data0", {24'd0, wd_q[wb]}, 8'hFF);
        chk("t1_data1", {24'd0, wd_q[wb + 1]}, 8'hFF);
        chk("t1_pix", pix_count, 2);
        chk("t1_clip", clip_count, 2);
        chk("t1_done_pulses", dones - d0, 1);
        chk("t1_start_pulses", starts - s0, 1);

        // 2: backpressure from a stalled write port
        fb_ack = 1'b1;
        start_run;
        fb_ack = 1'b0;
        wb = wa_q.size();
        tick;
        send(1, 0, 1'b1, 1'b0);
        send(2, 0, 1'b1, 1'b0);
        gen_valid = 1'b1;
        gen_out0  = 0;
        gen_out1  = 1;
        for (int i = 0; i < 10; i++) begin
            chk("t2_ready_low_full", {31'd0, gen_ready}, 0);
            chk("t2_we_held", {31'd0, fb_we}, 1);
            chk("t2_addr_stable", {20'd0, fb_addr}, 1);
            tick;
        end
        fb_ack = 1'b1;
        send(0, 1, 1'b1, 1'b0);
        send(63, 63, 1'b1, 1'b0);
        send(10, 20, 1'b1, 1'b0);
        send(0, 0, 1'b0, 1'b1);
        wait_done;
        chk("t2_writes", wa_q.size() - wb, 5);
        chk("t2_addr0", {20'd0, wa_q[wb]}, 1);
        chk("t2_addr1", {20'd0, wa_q[wb + 1]}, 2);
        chk("t2_addr2", {20'd0, wa_q[wb + 2]}, 64);
        chk("t2_addr3", {20'd0, wa_q[wb + 3]}, 4095);
        chk("t2_addr4", {20'd0, wa_q[wb + 4]}, 1290);
        chk("t2_pix", pix_count, 5);
        chk("t2_clip", clip_count, 0);

        // 3: last pair together with _done
        fb_ack = 1'b1;
        start_run;
        wb = wa_q.size();
        tick;
        send(50, 48, 1'b1, 1'b1);
        chk("t3_drain_ready_low", {31'd0, gen_ready}, 0);
        chk("t3_drain_busy", {31'd0, host_busy}, 1);
        chk("t3_drain_we", {31'd0, fb_we}, 1);
        chk("t3_drain_addr", {20'd0, fb_addr}, 3122);
        wait_done;
        chk("t3_writes", wa_q.size() - wb, 1);
        chk("t3_addr", {20'd0, wa_q[wb]}, 3122);
        chk("t3_pix", pix_count, 1);

        // 4: asynchronous reset with the FIFO full
        fb_ack = 1'b1;
        start_run;
        fb_ack = 1'b0;
        wb = wa_q.size();
        tick;
        send(5, 5, 1'b1, 1'b0);
        send(6, 6, 1'b1, 1'b0);
        chk("t4_full_ready", {31'd0, gen_ready}, 0);
        chk("t4_full_we", {31'd0, fb_we}, 1);
        #2 rst = 1'b1;
        #1;
        chk("t4_rst_busy", {31'd0, host_busy}, 0);
        chk("t4_rst_we", {31'd0, fb_we}, 0);
        chk("t4_rst_addr", {20'd0, fb_addr}, 0);
        chk("t4_rst_wdata", {24'd0, fb_wdata}, 0);
        chk("t4_rst_ready", {31'd0, gen_ready}, 0);
        chk("t4_rst_start", {31'd0, gen_start}, 0);
        chk("t4_rst_done", {31'd0, host_done}, 0);
        tick;
        rst    = 1'b0;
        fb_ack = 1'b1;
        tick;
        tick;
        tick;
        chk("t4_no_writes_after_rst", wa_q.size() - wb, 0);
        chk("t4_pix_zero", pix_count, 0);
        start_run;
        wb = wa_q.size();
        tick;
        send(3, 3, 1'b1, 1'b0);
        send(0, 0, 1'b0, 1'b1);
        wait_done;
        chk("t4_rerun_writes", wa_q.size() - wb, 1);
        chk("t4_rerun_addr", {20'd0, wa_q[wb]}, 195);
        chk("t4_rerun_pix", pix_count, 1);
        chk("t4_rerun_clip", clip_count, 0);

        // 6: empty run, host_go while busy
        fb_ack = 1'b1;
        s0 = starts;
        d0 = dones;
        start_run;
        wb = wa_q.size();
        tick;
        host_go = 1'b1;
        tick;
        host_go = 1'b0;
        send(0, 0, 1'b0, 1'b1);
        wait_done;
        tick;
        tick;
        tick;
        chk("t6_starts", starts - s0, 1);
        chk("t6_dones", dones - d0, 1);
        chk("t6_pix", pix_count, 0);
        chk("t6_clip", clip_count, 0);
        chk("t6_writes", wa_q.size() - wb, 0);
        chk("t6_idle", {31'd0, host_busy}, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
